// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the cache <-> memory_controller block-fetch path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: FSM state type, port owner type, address/block widths shared with
// the caches and memory_controller.
package mem_arb_pkg;

    localparam int ADDRSZ  = 64;
    localparam int BLOCKSZ = 64 * 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the icache, dcache and memory_controller sides of the arbiter.
// Latency: n/a (wiring only).
// Backpressure: requesters hold *_req until their *_valid pulse; no ready path.
//
// Modports:
//   slave  - the arbiter: takes cache requests and memory data, drives
//            responses, the memory request and status.
//   master - the environment (caches + memory_controller).
interface mem_port_arbiter_if #(
    parameter int ADDRSZ  = mem_arb_pkg::ADDRSZ,
    parameter int BLOCKSZ = mem_arb_pkg::BLOCKSZ
);
    // icache side
    logic               i_req;
    logic [ADDRSZ-1:0]  i_addr;
    logic               i_valid;
    logic [BLOCKSZ-1:0] i_rdata;
    // dcache side
    logic               d_req;
    logic [ADDRSZ-1:0]  d_addr;
    logic               d_we;
    logic [BLOCKSZ-1:0] d_wdata;
    logic               d_valid;
    logic [BLOCKSZ-1:0] d_rdata;
    // memory_controller side
    logic [ADDRSZ-1:0]  mem_address;
    logic               mem_start_req;
    logic               mem_wr_en;
    logic [BLOCKSZ-1:0] mem_wdata;
    logic [BLOCKSZ-1:0] mem_data_in;
    logic               mem_data_valid;
    // status
    logic               busy;
    logic               timeout_err;

    modport slave (
        input  i_req, i_addr, d_req, d_addr, d_we, d_wdata,
               mem_data_in, mem_data_valid,
        output i_valid, i_rdata, d_valid, d_rdata,
               mem_address, mem_start_req, mem_wr_en, mem_wdata,
               busy, timeout_err
    );

    modport master (
        output i_req, i_addr, d_req, d_addr, d_we, d_wdata,
               mem_data_in, mem_data_valid,
        input  i_valid, i_rdata, d_valid, d_rdata,
               mem_address, mem_start_req, mem_wr_en, mem_wdata,
               busy, timeout_err
    );

endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-input round-robin grant: on a tie the port that did not win last gets it.
// Latency: grant is combinational from the requests; last_grant updates on the clock after update.
// Backpressure: none; the caller decides when a grant is taken and strobes update.
//
// Ports: clk, reset (sync, active-high); req_i/req_d requests;
//        update + update_own record the owner of a completed transaction;
//        grant_vld/grant_own the current grant.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   req_i,
    input  logic   req_d,
    input  logic   update,
    input  owner_t update_own,
    output logic   grant_vld,
    output owner_t grant_own
);

    owner_t last_grant_q;
    owner_t last_grant_d;

    always_comb begin
        last_grant_d = last_grant_q;
        if (update) begin
            last_grant_d = update_own;
        end
    end

    // Reset to D so that I wins the first tie after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= OWN_D;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        grant_vld = req_i | req_d;
        grant_own = OWN_I;
        if (req_i && req_d) begin
            grant_own = (last_grant_q == OWN_I) ? OWN_D : OWN_I;
        end else if (req_d) begin
            grant_own = OWN_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the memory_controller block-fetch port between icache (I) and dcache (D), one transaction at a time.
// Latency: req sampled at cycle 0, mem_start_req at 1, data_valid at N, owner valid + rdata at N+1.
// Backpressure: requests wait (held high) while busy; memory has no backpressure, only a data_valid strobe.
//
// Ports: clk, reset (sync, active-high); bus (slave modport) carrying both cache
//        ports, the memory_controller handshake, busy and the sticky timeout_err.
module mem_port_arbiter #(
    parameter int ADDRSZ         = mem_arb_pkg::ADDRSZ,
    parameter int BLOCKSZ        = mem_arb_pkg::BLOCKSZ,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);
    import mem_arb_pkg::*;

    localparam int              CNTW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNTW-1:0] TMO_MAX = CNTW'(TIMEOUT_CYCLES);

    state_t             state_q,         state_d;
    owner_t             owner_q,         owner_d;
    logic [ADDRSZ-1:0]  mem_address_q,   mem_address_d;
    logic               mem_start_req_q, mem_start_req_d;
    logic               mem_wr_en_q,     mem_wr_en_d;
    logic [BLOCKSZ-1:0] mem_wdata_q,     mem_wdata_d;
    logic               i_valid_q,       i_valid_d;
    logic [BLOCKSZ-1:0] i_rdata_q,       i_rdata_d;
    logic               d_valid_q,       d_valid_d;
    logic [BLOCKSZ-1:0] d_rdata_q,       d_rdata_d;
    logic               busy_q,          busy_d;
    logic               timeout_err_q,   timeout_err_d;
    logic [CNTW-1:0]    tmo_cnt_q,       tmo_cnt_d;

    logic   grant_vld;
    owner_t grant_own;
    logic   rsp_take;

    // A response is only accepted while waiting; strays elsewhere are dropped.
    assign rsp_take = (state_q == ST_WAIT) && bus.mem_data_valid;

    rr_arb2 u_rr_arb2 (
        .clk        (clk),
        .reset      (reset),
        .req_i      (bus.i_req),
        .req_d      (bus.d_req),
        .update     (rsp_take),
        .update_own (owner_q),
        .grant_vld  (grant_vld),
        .grant_own  (grant_own)
    );

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (grant_vld) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (bus.mem_data_valid) state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- outputs / datapath
    // Every output is a flop; this block computes the value each one takes at
    // the next edge. Latched request fields simply hold outside of a grant.
    always_comb begin
        owner_d         = owner_q;
        mem_address_d   = mem_address_q;
        mem_wr_en_d     = mem_wr_en_q;
        mem_wdata_d     = mem_wdata_q;
        mem_start_req_d = 1'b0;
        i_valid_d       = 1'b0;
        d_valid_d       = 1'b0;
        i_rdata_d       = i_rdata_q;
        d_rdata_d       = d_rdata_q;
        tmo_cnt_d       = tmo_cnt_q;
        timeout_err_d   = timeout_err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (grant_vld) begin
                    owner_d         = grant_own;
                    mem_start_req_d = 1'b1;
                    if (grant_own == OWN_D) begin
                        mem_address_d = bus.d_addr;
                        mem_wr_en_d   = bus.d_we;
                        mem_wdata_d   = bus.d_wdata;
                    end else begin
                        mem_address_d = bus.i_addr;
                        mem_wr_en_d   = 1'b0;
                        mem_wdata_d   = '0;
                    end
                end
            end
            ST_ISSUE: begin
                // start pulse drops as we enter WAIT; latched fields hold
            end
            ST_WAIT: begin
                // Saturate so a very long wait cannot wrap the counter.
                if (tmo_cnt_q != TMO_MAX) begin
                    tmo_cnt_d = tmo_cnt_q + CNTW'(1);
                end
                // Flag only; the transaction keeps waiting for its data.
                if (tmo_cnt_d == TMO_MAX) begin
                    timeout_err_d = 1'b1;
                end
                if (bus.mem_data_valid) begin
                    if (owner_q == OWN_D) begin
                        d_rdata_d = bus.mem_data_in;
                        d_valid_d = 1'b1;
                    end else begin
                        i_rdata_d = bus.mem_data_in;
                        i_valid_d = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                tmo_cnt_d = '0;
            end
            default: begin
                tmo_cnt_d = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q         <= OWN_I;
            mem_address_q   <= '0;
            mem_start_req_q <= 1'b0;
            mem_wr_en_q     <= 1'b0;
            mem_wdata_q     <= '0;
            i_valid_q       <= 1'b0;
            i_rdata_q       <= '0;
            d_valid_q       <= 1'b0;
            d_rdata_q       <= '0;
            busy_q          <= 1'b0;
            timeout_err_q   <= 1'b0;
            tmo_cnt_q       <= '0;
        end else begin
            owner_q         <= owner_d;
            mem_address_q   <= mem_address_d;
            mem_start_req_q <= mem_start_req_d;
            mem_wr_en_q     <= mem_wr_en_d;
            mem_wdata_q     <= mem_wdata_d;
            i_valid_q       <= i_valid_d;
            i_rdata_q       <= i_rdata_d;
            d_valid_q       <= d_valid_d;
            d_rdata_q       <= d_rdata_d;
            busy_q          <= busy_d;
            timeout_err_q   <= timeout_err_d;
            tmo_cnt_q       <= tmo_cnt_d;
        end
    end

    assign bus.mem_address   = mem_address_q;
    assign bus.mem_start_req = mem_start_req_q;
    assign bus.mem_wr_en     = mem_wr_en_q;
    assign bus.mem_wdata     = mem_wdata_q;
    assign bus.i_valid       = i_valid_q;
    assign bus.i_rdata       = i_rdata_q;
    assign bus.d_valid       = d_valid_q;
    assign bus.d_rdata       = d_rdata_q;
    assign bus.busy          = busy_q;
    assign bus.timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed steps followed by a randomized phase
// checked against a transaction-level timing model (grant cycle -> start at +1,
// data at start+lat, valid pulse one cycle later, free again the cycle after).
module tb_mem_port_arbiter;

    localparam int AW  = 64;
    localparam int BW  = 512;
    localparam int TMO = 16;

    logic clk;
    logic reset;

    mem_port_arbiter_if #(.ADDRSZ(AW), .BLOCKSZ(BW)) bus ();

    mem_port_arbiter #(
        .ADDRSZ         (AW),
        .BLOCKSZ        (BW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [BW-1:0] rand512();
        logic [BW-1:0] r;
        r = '0;
        for (int i = 0; i < BW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic do_reset();
        reset              = 1'b1;
        bus.i_req          = 1'b0;
        bus.i_addr         = '0;
        bus.d_req          = 1'b0;
        bus.d_addr         = '0;
        bus.d_we           = 1'b0;
        bus.d_wdata        = '0;
        bus.mem_data_in    = '0;
        bus.mem_data_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // data patterns for the directed steps
    logic [BW-1:0] pat_a, pat_b, pat_c, pat_e, pat_f, pat_w;

    // random-phase model state
    bit            m_last_d;
    bit            pend_i, pend_d, in_txn, txn_d, txn_we;
    int            gap_i, gap_d, start_at, valid_at, resp_at, free_at, lat;
    logic [AW-1:0] a_i, a_d, txn_addr;
    bit            we_d;
    logic [BW-1:0] wd_d, txn_wd, txn_rd, exp_i_rd, exp_d_rd;
    int            n_gi, n_gd;

    initial begin
        pat_a = rand512();
        pat_b = rand512();
        pat_c = rand512();
        pat_e = rand512();
        pat_f = rand512();
        pat_w = rand512();

        // ---------------- reset values
        do_reset();
        chk("rst_busy",  bus.busy, 0);
        chk("rst_start", bus.mem_start_req, 0);
        chk("rst_wr",    bus.mem_wr_en, 0);
        chk("rst_addr",  bus.mem_address, 0);
        chk("rst_ivld",  bus.i_valid, 0);
        chk("rst_dvld",  bus.d_valid, 0);
        chk("rst_err",   bus.timeout_err, 0);
        chk("rst_irdat", bus.i_rdata, 0);

        // ---------------- single I read, memory answers 3 cycles after start
        bus.i_req  = 1'b1;
        bus.i_addr = 64'h1000;
        tick();                                   // ISSUE
        chk("i1_start", bus.mem_start_req, 1);
        chk("i1_addr",  bus.mem_address, 64'h1000);
        chk("i1_wr",    bus.mem_wr_en, 0);
        chk("i1_busy",  bus.busy, 1);
        bus.i_addr = 64'hDEAD_0000;               // must not affect the latched address
        tick();                                   // WAIT
        chk("i1_start_drop", bus.mem_start_req, 0);
        chk("i1_addr_hold",  bus.mem_address, 64'h1000);
        tick();
        tick();                                   // start + 3
        bus.mem_data_valid = 1'b1;
        bus.mem_data_in    = pat_a;
        chk("i1_ivld_early", bus.i_valid, 0);
        tick();                                   // RESP
        chk("i1_ivld",  bus.i_valid, 1);
        chk("i1_irdat", bus.i_rdata, pat_a);
        chk("i1_dvld",  bus.d_valid, 0);
        bus.mem_data_valid = 1'b0;
        bus.i_req          = 1'b0;
        tick();                                   // IDLE
        chk("i1_ivld_one", bus.i_valid, 0);
        chk("i1_idle",     bus.busy, 0);
        chk("i1_irdat_hold", bus.i_rdata, pat_a);

        // ---------------- spurious valid in IDLE
        bus.mem_data_valid = 1'b1;
        bus.mem_data_in    = pat_b;
        tick();
        chk("sp_idle_ivld", bus.i_valid, 0);
        chk("sp_idle_dvld", bus.d_valid, 0);
        chk("sp_idle_busy", bus.busy, 0);
        chk("sp_idle_irdat", bus.i_rdata, pat_a);
        chk("sp_idle_drdat", bus.d_rdata, 0);
        bus.mem_data_valid = 1'b0;

        // ---------------- D read with a spurious valid during ISSUE
        bus.d_req   = 1'b1;
        bus.d_addr  = 64'h2000;
        bus.d_we    = 1'b0;
        bus.d_wdata = pat_w;
        tick();                                   // ISSUE
        chk("d1_start", bus.mem_start_req, 1);
        chk("d1_addr",  bus.mem_address, 64'h2000);
        bus.mem_data_valid = 1'b1;
        bus.mem_data_in    = pat_b;
        tick();                                   // WAIT
        chk("sp_iss_dvld", bus.d_valid, 0);
        chk("sp_iss_busy", bus.busy, 1);
        bus.mem_data_valid = 1'b0;
        tick();                                   // WAIT
        bus.mem_data_valid = 1'b1;
        bus.mem_data_in    = pat_c;
        tick();                                   // RESP
        chk("d1_dvld",  bus.d_valid, 1);
        chk("d1_drdat", bus.d_rdata, pat_c);
        chk("d1_ivld",  bus.i_valid, 0);
        chk("d1_irdat", bus.i_rdata, pat_a);
        bus.mem_data_valid = 1'b0;
        bus.d_req          = 1'b0;
        tick();
        chk("d1_idle", bus.busy, 0);

        // ---------------- timeout: 19 WAIT cycles, error after the 16th
        bus.i_req  = 1'b1;
        bus.i_addr = 64'h3000;
        tick();                                   // ISSUE
        chk("tmo_start", bus.mem_start_req, 1);
        for (int k = 1; k <= 19; k++) begin
            tick();
            chk("tmo_err", bus.timeout_err, (k >= TMO + 1));
        end
        bus.mem_data_valid = 1'b1;                // late answer
        bus.mem_data_in    = pat_e;
        tick();
        chk("tmo_ivld",  bus.i_valid, 1);
        chk("tmo_irdat", bus.i_rdata, pat_e);
        chk("tmo_err_hold", bus.timeout_err, 1);
        bus.mem_data_valid = 1'b0;
        bus.i_req          = 1'b0;
        tick();
        chk("tmo_sticky", bus.timeout_err, 1);
        chk("tmo_idle",   bus.busy, 0);

        // ---------------- reset during WAIT
        bus.i_req  = 1'b1;
        bus.i_addr = 64'h4000;
        tick();                                   // ISSUE
        chk("rw_start", bus.mem_start_req, 1);
        tick();                                   // WAIT
        tick();                                   // WAIT
        reset = 1'b1;
        tick();
        chk("rw_busy",  bus.busy, 0);
        chk("rw_start0", bus.mem_start_req, 0);
        chk("rw_addr",  bus.mem_address, 0);
        chk("rw_err",   bus.timeout_err, 0);
        chk("rw_irdat", bus.i_rdata, 0);
        reset              = 1'b0;
        bus.i_req          = 1'b0;
        bus.mem_data_valid = 1'b1;                // stale answer from the aborted fetch
        bus.mem_data_in    = pat_f;
        tick();
        chk("rw_ivld", bus.i_valid, 0);
        chk("rw_idle", bus.busy, 0);
        chk("rw_irdat_hold", bus.i_rdata, 0);
        bus.mem_data_valid = 1'b0;

        // ---------------- randomized phase, both ports requesting from reset
        do_reset();
        m_last_d = 1'b1;
        in_txn   = 1'b0;
        pend_i   = 1'b0;
        pend_d   = 1'b0;
        gap_i    = 0;
        gap_d    = 0;
        free_at  = 0;
        start_at = -10;
        valid_at = -10;
        resp_at  = -10;
        exp_i_rd = '0;
        exp_d_rd = '0;
        n_gi     = 0;
        n_gd     = 0;
        txn_d    = 1'b0;
        txn_we   = 1'b0;
        txn_addr = '0;
        txn_wd   = '0;
        txn_rd   = '0;

        for (int c = 0; c < 500; c++) begin
            // outputs of cycle c
            chk("r_start", bus.mem_start_req, in_txn && (c == start_at));
            if (in_txn && c == start_at) begin
                chk("r_addr", bus.mem_address, txn_addr);
                chk("r_wr",   bus.mem_wr_en, txn_we);
                if (txn_d) chk("r_wdata", bus.mem_wdata, txn_wd);
            end
            chk("r_busy", bus.busy, in_txn && (c >= start_at) && (c <= resp_at));
            chk("r_ivld", bus.i_valid, in_txn && (c == resp_at) && !txn_d);
            chk("r_dvld", bus.d_valid, in_txn && (c == resp_at) && txn_d);
            if (in_txn && c == resp_at) begin
                if (txn_d) begin
                    exp_d_rd  = txn_rd;
                    pend_d    = 1'b0;
                    bus.d_req = 1'b0;
                    gap_d     = $urandom_range(0, 3);
                end else begin
                    exp_i_rd  = txn_rd;
                    pend_i    = 1'b0;
                    bus.i_req = 1'b0;
                    gap_i     = $urandom_range(0, 3);
                end
                m_last_d = txn_d;
                in_txn   = 1'b0;
                free_at  = c + 1;
            end
            chk("r_irdat", bus.i_rdata, exp_i_rd);
            chk("r_drdat", bus.d_rdata, exp_d_rd);

            // inputs for cycle c: new requests
            if (!pend_i && c < 470) begin
                if (gap_i == 0) begin
                    pend_i     = 1'b1;
                    a_i        = {$urandom, $urandom};
                    a_i[AW-1]  = 1'b0;
                    bus.i_req  = 1'b1;
                    bus.i_addr = a_i;
                end else begin
                    gap_i--;
                end
            end
            if (!pend_d && c < 470) begin
                if (gap_d == 0) begin
                    pend_d      = 1'b1;
                    a_d         = {$urandom, $urandom};
                    a_d[AW-1]   = 1'b1;
                    we_d        = 1'($urandom_range(0, 1));
                    wd_d        = rand512();
                    bus.d_req   = 1'b1;
                    bus.d_addr  = a_d;
                    bus.d_we    = we_d;
                    bus.d_wdata = wd_d;
                end else begin
                    gap_d--;
                end
            end

            // grant decision: free port, round robin on a tie
            if (!in_txn && c >= free_at && (pend_i || pend_d)) begin
                txn_d    = pend_d && (!pend_i || !m_last_d);
                in_txn   = 1'b1;
                start_at = c + 1;
                lat      = $urandom_range(2, 5);
                valid_at = start_at + lat;
                resp_at  = valid_at + 1;
                txn_addr = txn_d ? a_d : a_i;
                txn_we   = txn_d ? we_d : 1'b0;
                txn_wd   = wd_d;
                txn_rd   = rand512();
                if (txn_d) n_gd++; else n_gi++;
            end else if (in_txn && c >= start_at && c < resp_at) begin
                // owner scribbles on its address after the grant
                if (txn_d) bus.d_addr = {1'b1, 63'($urandom)};
                else       bus.i_addr = {1'b0, 63'($urandom)};
            end

            // memory model: real answer, quiet WAIT, or random strays elsewhere
            if (in_txn && c == valid_at) begin
                bus.mem_data_valid = 1'b1;
                bus.mem_data_in    = txn_rd;
            end else if (in_txn && c > start_at && c < valid_at) begin
                bus.mem_data_valid = 1'b0;
                bus.mem_data_in    = rand512();
            end else begin
                bus.mem_data_valid = ($urandom_range(0, 3) == 0);
                bus.mem_data_in    = rand512();
            end
            tick();
        end

        $display("random phase: %0d I grants, %0d D grants", n_gi, n_gd);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory_controller block-fetch port between the instruction cache (port I) and the data cache (port D).
- Sits between both cache instances and memory_controller and replaces the direct cache-to-controller wiring.
- Runs one transaction at a time, chosen by round-robin arbitration.
- Latches the winner's request, sequences the controller handshake and steers the returned block plus a one-cycle valid pulse back to the winner.

Parameters:
ADDRSZ, 64, request address width
BLOCKSZ, 512, cache block width in bits (64*8)
TIMEOUT_CYCLES, 1024, number of WAIT cycles after which timeout_err is set

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
i_req  in  1  icache request; held high until i_valid
i_addr  in  ADDRSZ  icache block address
i_valid  out  1  one-cycle pulse: i_rdata valid, icache transaction done
i_rdata  out  BLOCKSZ  block returned to icache
d_req  in  1  dcache request; held high until d_valid
d_addr  in  ADDRSZ  dcache block address
d_we  in  1  dcache write (1) / read (0)
d_wdata  in  BLOCKSZ  dcache write-back block
d_valid  out  1  one-cycle pulse: dcache transaction done (rdata meaningful on reads only)
d_rdata  out  BLOCKSZ  block returned to dcache
mem_address  out  ADDRSZ  to memory_controller in_address
mem_start_req  out  1  to memory_controller start_req
mem_wr_en  out  1  write strobe qualifier toward memory
mem_wdata  out  BLOCKSZ  write block toward memory
mem_data_in  in  BLOCKSZ  from memory_controller data_out
mem_data_valid  in  1  from memory_controller data_valid
busy  out  1  high in every state except IDLE
timeout_err  out  1  sticky error flag, cleared only by reset

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP.
- All outputs are registered. Reset values:
  - state = IDLE
  - all valid, start, wr and err outputs = 0
  - address and data outputs = 0
  - last_grant = D, so I wins the first tie
  - timeout counter = 0
- IDLE:
  - If neither request is high, stay in IDLE.
  - If exactly one request is high, grant it.
  - If both are high, grant the port that is not last_grant.
  - On a grant: latch the winner's address; for D also latch d_we and d_wdata (I always latches we = 0); record the owner; go to ISSUE.
- ISSUE (exactly 1 cycle):
  - mem_start_req = 1.
  - mem_address, mem_wr_en and mem_wdata driven from the latched values.
  - Go to WAIT.
- WAIT:
  - mem_start_req = 0; address, wr_en and wdata hold their latched values.
  - The timeout counter increments each cycle.
  - When it reaches TIMEOUT_CYCLES, set timeout_err. The transaction is not aborted and keeps waiting.
  - On mem_data_valid: capture mem_data_in into the owner's rdata register, set last_grant = owner, go to RESP.
- RESP (1 cycle):
  - Owner's valid = 1; the other port's valid = 0.
  - Clear the timeout counter.
  - Go to IDLE.
- Latency: request sampled in IDLE at cycle 0; mem_start_req at cycle 1; data_valid at cycle N; owner valid and rdata at cycle N+1.
- Minimum turnaround: 4 cycles with N = 2. The next grant is possible at cycle N+2.
- rdata registers hold their value until overwritten by that port's next transaction.
- mem_data_valid in IDLE, ISSUE or RESP is ignored: no capture, no pulse.
- Requester drops req mid-transaction: the transaction still completes and the valid pulse is still issued. The requester must tolerate it.
- Requester changes addr while req is held: no effect, because the address is latched in IDLE.
- reset asserted in any state: return to IDLE next cycle. mem_start_req is not reissued. memory_controller is reset by the same signal.
- Fairness: with continuous requests from both ports, grants strictly alternate I, D, I, D...

Decomposition:
- Shared package mem_arb_pkg:
  - typedef state_t for the FSM states
  - typedef owner_t {OWN_I, OWN_D}
  - BLOCKSZ and ADDRSZ constants, shared with cache and memory_controller
- One sub-module: rr_arb2, the two-input round-robin grant function. It holds last_grant and exposes grant and an update strobe.
- FSM and datapath registers stay in mem_port_arbiter.

Test Plan:
- Single I read: i_req = 1, i_addr = 0x1000, memory returns valid 3 cycles after start with data pattern A -> mem_start_req pulses once with mem_address = 0x1000 and mem_wr_en = 0; i_valid pulses once with i_rdata = A; d_valid stays 0.
- Simultaneous first requests: i_req = d_req = 1 out of reset -> I granted first; D is issued at the cycle after i_valid; exactly 2 mem_start_req pulses occur, in that order.
- Continuous contention for 6 transactions -> grant order I, D, I, D, I, D; D writes show mem_wr_en = 1 and mem_wdata = d_wdata.
- Spurious mem_data_valid in IDLE and in ISSUE -> no valid pulse, rdata unchanged, state unaffected.
- Timeout: hold mem_data_valid = 0 with TIMEOUT_CYCLES = 16 -> timeout_err rises after 16 WAIT cycles and stays high after a late valid; the late valid still completes the transaction.
- Reset during WAIT -> next cycle busy = 0 and all outputs at reset values; a later valid from the old transaction produces no pulse.
